// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one 1-entry hold register per functional unit,
// a round-robin pick among held results, and a registered CDB broadcast.

// One per-FU hold register: refills combinationally behind a drain.
module cdb_hold_slot #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              drain,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_value,
  output logic              valid,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] value
);

  // Occupancy: a load on the same edge as a drain keeps the entry full.
  always_ff @(posedge clock) begin
    if (reset)      valid <= 1'b0;
    else if (flush) valid <= 1'b0;
    else if (load)  valid <= 1'b1;
    else if (drain) valid <= 1'b0;
  end

  // Payload needs no reset: it is only observed while valid is set.
  always_ff @(posedge clock) begin
    if (load) begin
      tag   <= in_tag;
      value <= in_value;
    end
  end

endmodule

module cdb_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int ROB_TAG_W = 5,
  parameter int DATA_W    = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [NUM_FU-1:0]                 fu_valid,
  input  logic [NUM_FU-1:0][ROB_TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU-1:0][DATA_W-1:0]     fu_value,
  output logic [NUM_FU-1:0]                 fu_ready,
  output logic                              cdb_valid,
  output logic [ROB_TAG_W-1:0]              cdb_tag,
  output logic [DATA_W-1:0]                 cdb_value,
  output logic [$clog2(NUM_FU)-1:0]         cdb_fu_idx
);

  localparam int IDX_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0]                hold_valid;
  logic [NUM_FU-1:0][ROB_TAG_W-1:0] hold_tag;
  logic [NUM_FU-1:0][DATA_W-1:0]    hold_value;
  logic [NUM_FU-1:0]                grant;
  logic [IDX_W-1:0]                 gnt_idx;
  logic                             gnt_any;
  logic [IDX_W-1:0]                 rr_ptr;
  int                               cand;

  genvar g;
  generate
    for (g = 0; g < NUM_FU; g++) begin : g_slot
      // An entry can take a new result when empty or when it drains this edge.
      assign fu_ready[g] = !flush && (!hold_valid[g] || grant[g]);

      cdb_hold_slot #(.TAG_W(ROB_TAG_W), .DATA_W(DATA_W)) u_slot (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .load     (fu_valid[g] && fu_ready[g]),
        .drain    (grant[g]),
        .in_tag   (fu_tag[g]),
        .in_value (fu_value[g]),
        .valid    (hold_valid[g]),
        .tag      (hold_tag[g]),
        .value    (hold_value[g])
      );

      // Tag 0 means "no tag" to consumers, so an FU must never send it.
      a_no_tag0: assert property (@(posedge clock) disable iff (reset)
                                  fu_valid[g] |-> (fu_tag[g] != '0));
    end
  endgenerate

  // Round-robin search from rr_ptr: first held entry wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int off = 0; off < NUM_FU; off++) begin
      cand = (int'(rr_ptr) + off) % NUM_FU;
      if (!gnt_any && hold_valid[cand]) begin
        gnt_any     = 1'b1;
        gnt_idx     = IDX_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

  // CDB broadcast register and pointer advance; idle drives tag/value to 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_value  <= '0;
      cdb_fu_idx <= '0;
      rr_ptr     <= '0;
    end else if (flush) begin
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_value  <= '0;
    end else if (gnt_any) begin
      cdb_valid  <= 1'b1;
      cdb_tag    <= hold_tag[gnt_idx];
      cdb_value  <= hold_value[gnt_idx];
      cdb_fu_idx <= gnt_idx;
      rr_ptr     <= (gnt_idx == IDX_W'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;
    end else begin
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_value  <= '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: per-FU source queues act as the functional units,
// a behavioural model predicts every cycle, directed scenarios pin literals.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = 5;
  localparam int DW = 32;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] value;
  } item_t;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   flush = 1'b0;
  logic [N-1:0]           fu_valid = '0;
  logic [N-1:0][TW-1:0]   fu_tag   = '0;
  logic [N-1:0][DW-1:0]   fu_value = '0;
  logic [N-1:0]           fu_ready;
  logic                   cdb_valid;
  logic [TW-1:0]          cdb_tag;
  logic [DW-1:0]          cdb_value;
  logic [$clog2(N)-1:0]   cdb_fu_idx;

  cdb_arbiter #(.NUM_FU(N), .ROB_TAG_W(TW), .DATA_W(DW)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .fu_valid   (fu_valid),
    .fu_tag     (fu_tag),
    .fu_value   (fu_value),
    .fu_ready   (fu_ready),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_value  (cdb_value),
    .cdb_fu_idx (cdb_fu_idx)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;
  bit armed    = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- FU sources ----------------
  item_t src_q [N][$];

  // A result leaves its FU queue only when the handshake completes.
  always @(posedge clock) begin
    if (!reset)
      for (int i = 0; i < N; i++)
        if (fu_valid[i] && fu_ready[i]) void'(src_q[i].pop_front());
  end

  // Present queue heads mid-cycle so they are stable at the next edge.
  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        fu_valid[i] = 1'b1;
        fu_tag[i]   = src_q[i][0].tag;
        fu_value[i] = src_q[i][0].value;
      end else begin
        fu_valid[i] = 1'b0;
        fu_tag[i]   = '0;
        fu_value[i] = '0;
      end
    end
  end

  // ---------------- behavioural model ----------------
  bit            m_full [N];
  item_t         m_held [N];
  int            m_ptr;
  logic          e_valid;
  logic [TW-1:0] e_tag;
  logic [DW-1:0] e_value;
  int            e_idx;

  // Which FU gets the bus: first full entry, looking from the pointer onward.
  function automatic int m_pick();
    for (int off = 0; off < N; off++)
      if (m_full[(m_ptr + off) % N]) return (m_ptr + off) % N;
    return -1;
  endfunction

  always @(posedge clock) begin
    int  k;
    bit  take [N];
    k = m_pick();
    if (reset) begin
      for (int i = 0; i < N; i++) m_full[i] = 0;
      m_ptr = 0; e_valid = 0; e_tag = '0; e_value = '0; e_idx = 0;
    end else begin
      for (int i = 0; i < N; i++)
        take[i] = fu_valid[i] && !flush && (!m_full[i] || k == i);
      if (flush) begin
        for (int i = 0; i < N; i++) m_full[i] = 0;
        e_valid = 0; e_tag = '0; e_value = '0;
      end else if (k >= 0) begin
        e_valid = 1; e_tag = m_held[k].tag; e_value = m_held[k].value; e_idx = k;
        m_full[k] = 0;
        m_ptr = (k + 1) % N;
      end else begin
        e_valid = 0; e_tag = '0; e_value = '0;
      end
      for (int i = 0; i < N; i++)
        if (take[i]) begin
          m_full[i] = 1;
          m_held[i].tag = fu_tag[i];
          m_held[i].value = fu_value[i];
        end
    end
  end

  // ---------------- per-cycle compare + broadcast log ----------------
  int            log_idx[$];
  logic [TW-1:0] log_tag[$];
  int            log_cyc[$];

  always @(negedge clock) begin
    int           k;
    logic [N-1:0] r;
    cyc++;
    if (armed) begin
      k = m_pick();
      for (int i = 0; i < N; i++) r[i] = !flush && (!m_full[i] || k == i);
      chk("cdb_valid", 64'(cdb_valid), 64'(e_valid));
      chk("cdb_tag", 64'(cdb_tag), 64'(e_tag));
      chk("cdb_value", 64'(cdb_value), 64'(e_value));
      chk("cdb_fu_idx", 64'(cdb_fu_idx), 64'(e_idx));
      chk("fu_ready", 64'(fu_ready), 64'(r));
    end
    if (cdb_valid === 1'b1) begin
      log_idx.push_back(int'(cdb_fu_idx));
      log_tag.push_back(cdb_tag);
      log_cyc.push_back(cyc);
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input int fu, input logic [TW-1:0] t, input logic [DW-1:0] v);
    item_t it;
    it.tag = t;
    it.value = v;
    src_q[fu].push_back(it);
  endtask

  task automatic clr_log();
    log_idx.delete(); log_tag.delete(); log_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    tick(2);
    reset = 1'b0;
    clr_log();
  endtask

  initial begin
    tick(1);
    armed = 1;
    tick(1);
    chk("reset cdb_valid", 64'(cdb_valid), 64'd0);
    chk("reset cdb_tag", 64'(cdb_tag), 64'd0);
    chk("reset cdb_fu_idx", 64'(cdb_fu_idx), 64'd0);
    reset = 1'b0;
    #1;
    chk("reset fu_ready", 64'(fu_ready), 64'hF);
    clr_log();

    // 1: single result from FU2, two edges of latency, then idle with tag 0
    push(2, 5'd5, 32'hDEAD_BEEF);
    tick(2);
    chk("t1 valid", 64'(cdb_valid), 64'd1);
    chk("t1 tag", 64'(cdb_tag), 64'd5);
    chk("t1 value", 64'(cdb_value), 64'hDEAD_BEEF);
    chk("t1 idx", 64'(cdb_fu_idx), 64'd2);
    tick(1);
    chk("t1 idle valid", 64'(cdb_valid), 64'd0);
    chk("t1 idle tag", 64'(cdb_tag), 64'd0);
    chk("t1 idle idx held", 64'(cdb_fu_idx), 64'd2);
    // pointer now 3: FU3 beats FU0 when both arrive together
    clr_log();
    push(0, 5'd7, 32'h70);
    push(3, 5'd9, 32'h90);
    tick(4);
    chk("t1 ptr3 count", 64'(log_idx.size()), 64'd2);
    if (log_idx.size() == 2) begin
      chk("t1 ptr3 first", 64'(log_idx[0]), 64'd3);
      chk("t1 ptr3 second", 64'(log_idx[1]), 64'd0);
    end

    // 2: all four at once from pointer 0 -> tags 1,2,3,4 then idle
    do_reset();
    for (int i = 0; i < N; i++) push(i, TW'(i + 1), 32'h1000_0000 + 32'(i));
    tick(1);
    for (int j = 0; j < N; j++) begin
      tick(1);
      chk("t2 tag", 64'(cdb_tag), 64'(j + 1));
      chk("t2 value", 64'(cdb_value), 64'(32'h1000_0000 + 32'(j)));
    end
    tick(1);
    chk("t2 end valid", 64'(cdb_valid), 64'd0);
    chk("t2 end tag", 64'(cdb_tag), 64'd0);

    // 3: lone FU0 streams 1..8 with no bubble
    do_reset();
    for (int t = 1; t <= 8; t++) push(0, TW'(t), 32'(t * 3));
    for (int j = 0; j < 8; j++) begin
      tick(1);
      chk("t3 fu_ready0", 64'(fu_ready[0]), 64'd1);
    end
    tick(3);
    chk("t3 count", 64'(log_tag.size()), 64'd8);
    if (log_tag.size() == 8)
      for (int j = 0; j < 8; j++) begin
        chk("t3 tag", 64'(log_tag[j]), 64'(j + 1));
        chk("t3 no bubble", 64'(log_cyc[j] - log_cyc[0]), 64'(j));
      end

    // 4: FU1 and FU3 contend from pointer 2 -> 3,1,3,1,...
    do_reset();
    push(1, 5'd10, 32'hA);
    tick(3);
    clr_log();
    for (int t = 0; t < 4; t++) begin
      push(1, TW'(5'h11 + t), 32'h100 + 32'(t));
      push(3, TW'(5'h19 + t), 32'h300 + 32'(t));
    end
    tick(12);
    chk("t4 count", 64'(log_idx.size()), 64'd8);
    if (log_idx.size() == 8)
      for (int j = 0; j < 8; j++) begin
        chk("t4 idx", 64'(log_idx[j]), (j % 2 == 0) ? 64'd3 : 64'd1);
        chk("t4 tag", 64'(log_tag[j]), (j % 2 == 0) ? 64'(5'h19 + j / 2) : 64'(5'h11 + j / 2));
        chk("t4 back-to-back", 64'(log_cyc[j] - log_cyc[0]), 64'(j));
      end

    // 5: flush with three entries held and a broadcast on the bus
    do_reset();
    for (int i = 0; i < N; i++) push(i, TW'(i + 1), 32'h5000 + 32'(i));
    tick(2);
    chk("t5 pre valid", 64'(cdb_valid), 64'd1);
    flush = 1'b1;
    #1;
    chk("t5 ready in flush", 64'(fu_ready), 64'd0);
    tick(1);
    flush = 1'b0;
    #1;
    chk("t5 valid", 64'(cdb_valid), 64'd0);
    chk("t5 tag", 64'(cdb_tag), 64'd0);
    chk("t5 value", 64'(cdb_value), 64'd0);
    chk("t5 ready", 64'(fu_ready), 64'hF);
    clr_log();
    tick(6);
    chk("t5 no stale", 64'(log_idx.size()), 64'd0);

    // 6: reset beats flush while a broadcast is live
    do_reset();
    push(2, 5'd2, 32'h22);
    push(3, 5'd3, 32'h33);
    tick(2);
    chk("t6 pre valid", 64'(cdb_valid), 64'd1);
    chk("t6 pre idx", 64'(cdb_fu_idx), 64'd2);
    reset = 1'b1;
    flush = 1'b1;
    tick(1);
    chk("t6 valid", 64'(cdb_valid), 64'd0);
    chk("t6 tag", 64'(cdb_tag), 64'd0);
    chk("t6 value", 64'(cdb_value), 64'd0);
    chk("t6 idx", 64'(cdb_fu_idx), 64'd0);
    reset = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    clr_log();
    push(3, 5'd13, 32'hD);
    push(1, 5'd11, 32'hB);
    tick(6);
    chk("t6 count", 64'(log_idx.size()), 64'd2);
    if (log_idx.size() == 2) begin
      chk("t6 first", 64'(log_idx[0]), 64'd1);
      chk("t6 second", 64'(log_idx[1]), 64'd3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
